// File: rtl/sh7604_ext_bus_bridge_if.sv
// Signal bundle between the SH7604 external bus pins, the bridge, and a generic request/acknowledge memory port.
// The bridge uses the slave modport. The CPU/memory environment uses the master modport.
interface sh7604_ext_bus_bridge_if;
    logic [26:0] A;
    logic [31:0] CPU_DO;
    logic        BS_N;
    logic [3:0]  CS_N;
    logic        RD_WR_N;
    logic        RD_N;
    logic [3:0]  WE_N;
    logic [31:0] CPU_DI;
    logic        WAIT_N;
    logic [26:0] MEM_A;
    logic [31:0] MEM_DO;
    logic [3:0]  MEM_BE;
    logic        MEM_WR;
    logic        MEM_REQ;
    logic [31:0] MEM_DI;
    logic        MEM_ACK;
    logic        TO_ERR;
    logic        TO_CLR;

    modport slave (
        input  A, CPU_DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N, MEM_DI, MEM_ACK, TO_CLR,
        output CPU_DI, WAIT_N, MEM_A, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, TO_ERR
    );

    modport master (
        output A, CPU_DO, BS_N, CS_N, RD_WR_N, RD_N, WE_N, MEM_DI, MEM_ACK, TO_CLR,
        input  CPU_DI, WAIT_N, MEM_A, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, TO_ERR
    );
endinterface

// File: rtl/sh7604_ext_bus_bridge.sv
// Turns each SH-2 external bus cycle on an enabled CS area into a single memory request.
// The CPU is held in WAIT until the memory port acknowledges or the bridge times out.
module sh7604_ext_bus_bridge #(
    parameter logic [3:0]  AREA_EN = 4'b1111,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CE_R,
    input  logic CE_F,
    sh7604_ext_bus_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [26:0] mem_a_q, mem_a_d;
    logic [31:0] mem_do_q, mem_do_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_req_q, mem_req_d;
    logic        wait_n_q, wait_n_d;
    logic [31:0] cpu_di_q, cpu_di_d;
    logic        to_err_q, to_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  cs_sel_q, cs_sel_d;

    logic [3:0]  hit_mask;
    logic        hit;
    logic [15:0] cnt_inc;
    logic        to_hit;
    logic        to_set;
    logic        cycle_over;

    always_comb begin
        hit_mask   = ~bus.CS_N & AREA_EN;
        hit        = ~bus.BS_N & (|hit_mask);
        cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        to_hit     = (TIMEOUT != 0) && (cnt_inc >= TO_LIMIT);
        // The cycle is over once the served chip select is released or all strobes are idle.
        cycle_over = ((bus.CS_N & cs_sel_q) == cs_sel_q) || (bus.RD_N && (bus.WE_N == 4'hF));
    end

    always_comb begin
        state_d   = state_q;
        mem_a_d   = mem_a_q;
        mem_do_d  = mem_do_q;
        mem_be_d  = mem_be_q;
        mem_wr_d  = mem_wr_q;
        mem_req_d = mem_req_q;
        wait_n_d  = wait_n_q;
        cpu_di_d  = cpu_di_q;
        cnt_d     = cnt_q;
        cs_sel_d  = cs_sel_q;
        to_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (CE_F && hit) begin
                    state_d   = WAIT_ACK;
                    mem_a_d   = bus.A;
                    mem_do_d  = bus.CPU_DO;
                    mem_wr_d  = ~bus.RD_WR_N;
                    mem_be_d  = bus.RD_WR_N ? 4'hF : ~bus.WE_N;
                    mem_req_d = 1'b1;
                    wait_n_d  = 1'b0;
                    cnt_d     = 16'd0;
                    cs_sel_d  = hit_mask;
                end
            end
            WAIT_ACK: begin
                // The ACK is checked before the timeout, so a coincident ACK completes normally.
                if (bus.MEM_ACK) begin
                    mem_req_d = 1'b0;
                    if (!mem_wr_q) cpu_di_d = bus.MEM_DI;
                    state_d   = DONE;
                end else if (CE_R) begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        mem_req_d = 1'b0;
                        if (!mem_wr_q) cpu_di_d = TO_DATA;
                        to_set    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                // WAIT_N is released on a falling phase, so the CPU samples it on its next rising phase.
                if (CE_F) begin
                    wait_n_d = 1'b1;
                    if (cycle_over) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        to_err_d = to_set ? 1'b1 : (bus.TO_CLR ? 1'b0 : to_err_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            mem_a_q   <= '0;
            mem_do_q  <= '0;
            mem_be_q  <= '0;
            mem_wr_q  <= 1'b0;
            mem_req_q <= 1'b0;
            wait_n_q  <= 1'b1;
            cpu_di_q  <= '0;
            to_err_q  <= 1'b0;
            cnt_q     <= '0;
            cs_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            mem_a_q   <= mem_a_d;
            mem_do_q  <= mem_do_d;
            mem_be_q  <= mem_be_d;
            mem_wr_q  <= mem_wr_d;
            mem_req_q <= mem_req_d;
            wait_n_q  <= wait_n_d;
            cpu_di_q  <= cpu_di_d;
            to_err_q  <= to_err_d;
            cnt_q     <= cnt_d;
            cs_sel_q  <= cs_sel_d;
        end
    end

    assign bus.CPU_DI  = cpu_di_q;
    assign bus.WAIT_N  = wait_n_q;
    assign bus.MEM_A   = mem_a_q;
    assign bus.MEM_DO  = mem_do_q;
    assign bus.MEM_BE  = mem_be_q;
    assign bus.MEM_WR  = mem_wr_q;
    assign bus.MEM_REQ = mem_req_q;
    assign bus.TO_ERR  = to_err_q;

endmodule

// File: tb/tb_sh7604_ext_bus_bridge.sv
// Directed bench for sh7604_ext_bus_bridge.
// The CPU clock runs at CLK/4, with CE_R on phase 0 and CE_F on phase 2.
module tb_sh7604_ext_bus_bridge;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] phase = 2'd0;
    logic       ce_r, ce_f;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) phase <= phase + 2'd1;
    assign ce_r = (phase == 2'd0);
    assign ce_f = (phase == 2'd2);

    sh7604_ext_bus_bridge_if bus_if();

    sh7604_ext_bus_bridge #(
        .AREA_EN (4'b0111),
        .TIMEOUT (8),
        .TO_DATA (32'hFFFF_FFFF)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE_R  (ce_r),
        .CE_F  (ce_f),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clk_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic ce_f_edge();
        bit seen;
        seen = 1'b0;
        while (!seen) begin
            @(negedge CLK);
            seen = ce_f;
        end
        clk_edge();
    endtask

    task automatic ce_r_edge();
        bit seen;
        seen = 1'b0;
        while (!seen) begin
            @(negedge CLK);
            seen = ce_r;
        end
        clk_edge();
    endtask

    task automatic bus_idle();
        bus_if.BS_N    = 1'b1;
        bus_if.CS_N    = 4'hF;
        bus_if.RD_N    = 1'b1;
        bus_if.WE_N    = 4'hF;
        bus_if.RD_WR_N = 1'b1;
    endtask

    task automatic start_read(input logic [26:0] a, input logic [3:0] cs);
        bus_if.A       = a;
        bus_if.CPU_DO  = 32'h0;
        bus_if.CS_N    = cs;
        bus_if.RD_WR_N = 1'b1;
        bus_if.RD_N    = 1'b0;
        bus_if.WE_N    = 4'hF;
        bus_if.BS_N    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cycles;
        int rises;
        logic prev_req;

        bus_idle();
        bus_if.A = 27'h0; bus_if.CPU_DO = 32'h0;
        bus_if.MEM_DI = 32'h0; bus_if.MEM_ACK = 1'b0; bus_if.TO_CLR = 1'b0;
        repeat (3) clk_edge();
        check("rst_req",    32'(bus_if.MEM_REQ), 32'd0);
        check("rst_wait",   32'(bus_if.WAIT_N),  32'd1);
        check("rst_cpu_di", bus_if.CPU_DI,       32'h0);
        check("rst_to_err", 32'(bus_if.TO_ERR),  32'd0);
        check("rst_mem_a",  32'(bus_if.MEM_A),   32'h0);
        check("rst_mem_be", 32'(bus_if.MEM_BE),  32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        ce_f_edge();

        // Read hit on CS0, slave acknowledges after 5 CLK.
        start_read(27'h0000100, 4'b1110);
        ce_f_edge();
        check("rd_req_rise", 32'(bus_if.MEM_REQ), 32'd1);
        check("rd_wait_low", 32'(bus_if.WAIT_N),  32'd0);
        check("rd_addr",     32'(bus_if.MEM_A),   32'h100);
        check("rd_be",       32'(bus_if.MEM_BE),  32'hF);
        check("rd_wr",       32'(bus_if.MEM_WR),  32'd0);
        bus_if.BS_N = 1'b1;
        req_cycles = 1;
        repeat (4) begin
            clk_edge();
            if (bus_if.MEM_REQ) req_cycles++;
        end
        bus_if.MEM_DI = 32'h12345678; bus_if.MEM_ACK = 1'b1;
        clk_edge();
        bus_if.MEM_ACK = 1'b0; bus_if.MEM_DI = 32'h0;
        if (bus_if.MEM_REQ) req_cycles++;
        check("rd_req_cycles", req_cycles,          32'd5);
        check("rd_wait_held",  32'(bus_if.WAIT_N),  32'd0);
        check("rd_data",       bus_if.CPU_DI,       32'h12345678);
        ce_f_edge();
        check("rd_wait_rel",   32'(bus_if.WAIT_N),  32'd1);
        check("rd_data_hold",  bus_if.CPU_DI,       32'h12345678);
        bus_idle();
        ce_f_edge(); ce_f_edge();
        $display("txn read   A=%h data=%h req_cycles=%0d", 27'h100, bus_if.CPU_DI, req_cycles);

        // Byte write on CS2; the strobes stay asserted well past the acknowledge.
        bus_if.A = 27'h0400200; bus_if.CPU_DO = 32'h00AB0000;
        bus_if.CS_N = 4'b1011; bus_if.RD_WR_N = 1'b0; bus_if.RD_N = 1'b1;
        bus_if.WE_N = 4'b1101; bus_if.BS_N = 1'b0;
        ce_f_edge();
        check("wr_req",  32'(bus_if.MEM_REQ), 32'd1);
        check("wr_wr",   32'(bus_if.MEM_WR),  32'd1);
        check("wr_be",   32'(bus_if.MEM_BE),  32'b0010);
        check("wr_data", bus_if.MEM_DO,       32'h00AB0000);
        check("wr_addr", 32'(bus_if.MEM_A),   32'h0400200);
        bus_if.MEM_ACK = 1'b1;
        clk_edge();
        bus_if.MEM_ACK = 1'b0;
        check("wr_req_drop", 32'(bus_if.MEM_REQ), 32'd0);
        rises = 0;
        prev_req = bus_if.MEM_REQ;
        repeat (40) begin
            clk_edge();
            if (bus_if.MEM_REQ && !prev_req) rises++;
            prev_req = bus_if.MEM_REQ;
        end
        check("wr_single_req", rises,              32'd0);
        check("wr_wait_rel",   32'(bus_if.WAIT_N), 32'd1);
        bus_idle();
        ce_f_edge(); ce_f_edge();
        $display("txn write  A=%h data=%h be=%b extra_reqs=%0d", 27'h0400200, 32'h00AB0000, 4'b0010, rises);

        // Cycle on CS3, which this instance does not serve.
        start_read(27'h0600000, 4'b0111);
        repeat (3) begin
            ce_f_edge();
            check("dis_req",  32'(bus_if.MEM_REQ), 32'd0);
            check("dis_wait", 32'(bus_if.WAIT_N),  32'd1);
        end
        bus_idle();
        ce_f_edge();
        $display("txn disabled-area CS3 ignored");

        // Read on CS1 with no acknowledge, so it must time out after 8 CE_R.
        start_read(27'h0200040, 4'b1101);
        ce_f_edge();
        check("to_req", 32'(bus_if.MEM_REQ), 32'd1);
        bus_if.BS_N = 1'b1;
        repeat (7) ce_r_edge();
        check("to_req_before", 32'(bus_if.MEM_REQ), 32'd1);
        ce_r_edge();
        check("to_req_drop", 32'(bus_if.MEM_REQ), 32'd0);
        check("to_data",     bus_if.CPU_DI,       32'hFFFFFFFF);
        check("to_err_set",  32'(bus_if.TO_ERR),  32'd1);
        ce_f_edge();
        check("to_wait_rel", 32'(bus_if.WAIT_N),  32'd1);
        bus_idle();
        ce_f_edge(); ce_f_edge();
        check("to_err_sticky", 32'(bus_if.TO_ERR), 32'd1);
        bus_if.TO_CLR = 1'b1;
        clk_edge();
        bus_if.TO_CLR = 1'b0;
        check("to_err_clr", 32'(bus_if.TO_ERR), 32'd0);
        $display("txn timeout A=%h data=%h", 27'h0200040, 32'hFFFFFFFF);

        // The acknowledge lands on the same edge as the 8th CE_R.
        start_read(27'h0000200, 4'b1110);
        ce_f_edge();
        bus_if.BS_N = 1'b1;
        repeat (7) ce_r_edge();
        while (!ce_r) clk_edge();
        bus_if.MEM_ACK = 1'b1; bus_if.MEM_DI = 32'hCAFEF00D;
        clk_edge();
        bus_if.MEM_ACK = 1'b0; bus_if.MEM_DI = 32'h0;
        check("race_req",  32'(bus_if.MEM_REQ), 32'd0);
        check("race_data", bus_if.CPU_DI,       32'hCAFEF00D);
        check("race_err",  32'(bus_if.TO_ERR),  32'd0);
        ce_f_edge();
        bus_idle();
        ce_f_edge(); ce_f_edge();
        $display("txn ack/timeout race data=%h", 32'hCAFEF00D);

        // Reset asserted in WAIT_ACK, then a normal read afterwards.
        start_read(27'h0000300, 4'b1110);
        ce_f_edge();
        check("mid_req", 32'(bus_if.MEM_REQ), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_req",  32'(bus_if.MEM_REQ), 32'd0);
        check("mid_rst_wait", 32'(bus_if.WAIT_N),  32'd1);
        check("mid_rst_a",    32'(bus_if.MEM_A),   32'h0);
        check("mid_rst_di",   bus_if.CPU_DI,       32'h0);
        check("mid_rst_be",   32'(bus_if.MEM_BE),  32'h0);
        bus_idle();
        @(negedge CLK);
        RST_N = 1'b1;
        ce_f_edge();
        start_read(27'h0000304, 4'b1110);
        ce_f_edge();
        check("post_addr", 32'(bus_if.MEM_A), 32'h304);
        bus_if.BS_N = 1'b1;
        bus_if.MEM_DI = 32'h5A5AA5A5; bus_if.MEM_ACK = 1'b1;
        clk_edge();
        bus_if.MEM_ACK = 1'b0; bus_if.MEM_DI = 32'h0;
        check("post_data", bus_if.CPU_DI, 32'h5A5AA5A5);
        ce_f_edge();
        check("post_wait", 32'(bus_if.WAIT_N), 32'd1);
        bus_idle();
        ce_f_edge();
        $display("txn reset-abort then read data=%h", 32'h5A5AA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
